imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
//  Inverse of the core's immediate decoder. Packs a 32-bit immediate into the
//  immediate fields of an RV32I instruction template (I/S/B/U/J), range-checks it,
//  and can expand an out-of-range ADDI into a LUI+ADDI pair. Serves the BIOS
//  patcher and the instruction-injection path. Valid/ready on both sides, with a
//  1-entry registered output.
// PARAMETERS
//  EXPAND_EN  1  1: LUI+ADDI expansion hardware present; 0: in_expand ignored
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   request valid
//  in_ready     out  1   request accepted when in_valid && in_ready
//  in_inst      in   32  template; immediate-field bits ignored, all others kept
//  in_imm       in   32  immediate value to encode
//  in_imm_type  in   3   0=I 1=S 2=B 3=U 4=J; 5..7 invalid
//  in_expand    in   1   allow LUI+ADDI expansion (type I only)
//  out_valid    out  1   output word valid
//  out_ready    in   1   consumer takes word when out_valid && out_ready
//  out_inst     out  32  encoded instruction
//  out_err      out  1   immediate not representable, or invalid type
//  out_last     out  1   final word of this request
// BEHAVIOUR
//  Reset: state S_IDLE; out_valid=0, out_inst=0, out_err=0, out_last=0.
//  Field packing, all other bits taken from in_inst:
//   I: [31:20]=imm[11:0]
//   S: [31:25]=imm[11:5], [11:7]=imm[4:0]
//   B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]
//   U: [31:12]=imm[31:12]
//   J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]
//   invalid type: out_inst=in_inst, out_err=1
//  Range check (err=1, truncated bits still packed):
//   I/S: imm != sext(imm[11:0]); B: imm != sext(imm[12:0]) or imm[0];
//   J: imm != sext(imm[20:0]) or imm[0]; U: imm[11:0] != 0
//  Expansion condition: EXPAND_EN && in_expand && type I && out of range
//   && in_inst[6:0]=0010011 && in_inst[14:12]=000.
//   Word 1: LUI rd, hi, with hi = imm[31:12] + imm[11] (mod 2^20), last=0.
//   Word 2: ADDI rd, rd, imm[11:0] (rs1 replaced by rd), last=1.
//   err=0 on both words.
//  FSM: S_IDLE (no output held), S_ONE (single word held),
//   S_HI (LUI held), S_LO (ADDI held).
//   IDLE/ONE/LO with accept -> HI if expanding, else ONE.
//   ONE/LO with out_ready and no accept -> IDLE.
//   HI with out_ready -> LO. LO is loaded from a registered copy of the
//   request, so in_* are not needed after acceptance.
//  in_ready = IDLE | ((ONE|LO) & out_ready); always 0 in HI.
//   Simultaneous drain and accept: new word loads in the same edge. Full rate
//   1 word/cycle; an expanded request takes 2 cycles.
//  Latency: accept at edge N -> out_valid=1 after edge N.
//  out_* held stable while out_valid && !out_ready.
//  rst_n low at any time (including S_HI): immediate return to reset values.
//   The pending LO word is discarded.
// STRUCTURE
//  Shared package: IMM_I..IMM_J codes (shared with the decoder), OP_LUI=0110111,
//   OP_OPIMM=0010011, F3_ADDI=000, FSM state encodings.
//  Sub-module imm_pack: combinational packer plus range check
//   (inst, imm, type -> packed, err). Instantiated once; the FSM and registers
//   live in imm_encoder.
// TESTING
//  I: tmpl 0x00000293, imm 0xFFFFF800 -> 0x80000293, err=0, last=1
//  S: tmpl 0x0000A023, imm 0x000007FC -> 0x7E00AE23, err=0
//  B: tmpl 0x00000063, imm 0x00000003 -> err=1; I imm 0x800, in_expand=0 -> err=1
//  Expand: tmpl 0x00000293, imm 0x12345FFF, in_expand=1
//   -> 0x123462B7 (last=0), then 0xFFF28293 (last=1); in_ready=0 while in S_HI
//  Backpressure: out_ready=0 for 3 cycles, in_valid held
//   -> out_inst stable, in_ready=0, no word lost or duplicated
//  Reset pulse while in S_HI -> out_valid=0 next cycle, ADDI never emitted
//  Random: 10k imm/type pairs decoded back by the immediate decoder
//   -> decoded value == in_imm whenever err=0

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder and the core's immediate decoder.
// Holds the immediate-format codes, the opcode/funct3 values used when an ADDI is
// split into LUI+ADDI, and the encoder FSM state encoding.
package imm_encoder_pkg;

   // Immediate format codes; values 5..7 are invalid.
   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_OPIMM = 7'b0010011;
   localparam logic [2:0] F3_ADDI  = 3'b000;

   // S_IDLE: nothing held; S_ONE: single word held;
   // S_HI: LUI of an expansion held; S_LO: trailing ADDI held.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ONE  = 2'd1,
      S_HI   = 2'd2,
      S_LO   = 2'd3
   } enc_state_e;

   // Sign-extend a 12-bit immediate to 32 bits.
   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational immediate packer with range check.
// Places the immediate into the field layout of the selected RV32I format and
// keeps every other template bit. err flags an immediate that the format cannot
// represent (the truncated bits are still packed) or an invalid format code, in
// which case the template passes through unchanged.
// Ports:
//   inst        in   32  instruction template
//   imm         in   32  immediate value
//   imm_type    in   3   format code (IMM_I..IMM_J)
//   packed_inst out  32  template with immediate fields filled in
//   err         out  1   not representable, or invalid format
module imm_pack
   import imm_encoder_pkg::*;
(
   input  logic [31:0] inst,
   input  logic [31:0] imm,
   input  logic [2:0]  imm_type,
   output logic [31:0] packed_inst,
   output logic        err
);

   logic [31:0] sext_12;
   logic [31:0] sext_13;
   logic [31:0] sext_21;

   assign sext_12 = sext12(imm[11:0]);
   assign sext_13 = {{19{imm[12]}}, imm[12:0]};
   assign sext_21 = {{11{imm[20]}}, imm[20:0]};

   always_comb begin
      packed_inst = inst;
      err         = 1'b0;
      case (imm_type)
         IMM_I: begin
            packed_inst[31:20] = imm[11:0];
            err                = (imm != sext_12);
         end
         IMM_S: begin
            packed_inst[31:25] = imm[11:5];
            packed_inst[11:7]  = imm[4:0];
            err                = (imm != sext_12);
         end
         IMM_B: begin
            packed_inst[31]    = imm[12];
            packed_inst[7]     = imm[11];
            packed_inst[30:25] = imm[10:5];
            packed_inst[11:8]  = imm[4:1];
            // Branch offsets are halfword aligned; bit 0 has no field.
            err                = (imm != sext_13) | imm[0];
         end
         IMM_U: begin
            packed_inst[31:12] = imm[31:12];
            err                = |imm[11:0];
         end
         IMM_J: begin
            packed_inst[31]    = imm[20];
            packed_inst[19:12] = imm[19:12];
            packed_inst[20]    = imm[11];
            packed_inst[30:21] = imm[10:1];
            err                = (imm != sext_21) | imm[0];
         end
         default: begin
            err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: inverse of the core's immediate decoder.
// Accepts a template plus immediate, packs and range-checks it, and presents the
// result through a 1-entry registered output. An out-of-range ADDI may be split
// into LUI rd,hi followed by ADDI rd,rd,lo; the ADDI is kept in a private
// register so the request side is free once the request is accepted.
// Parameters:
//   EXPAND_EN    1: LUI+ADDI expansion present; 0: in_expand ignored
// Ports:
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   in_valid     in   1   request valid
//   in_ready     out  1   request accepted when in_valid && in_ready
//   in_inst      in   32  template; immediate-field bits ignored
//   in_imm       in   32  immediate value to encode
//   in_imm_type  in   3   0=I 1=S 2=B 3=U 4=J; 5..7 invalid
//   in_expand    in   1   allow LUI+ADDI expansion (type I only)
//   out_valid    out  1   output word valid
//   out_ready    in   1   consumer takes word when out_valid && out_ready
//   out_inst     out  32  encoded instruction
//   out_err      out  1   immediate not representable, or invalid type
//   out_last     out  1   final word of this request
module imm_encoder
   import imm_encoder_pkg::*;
#(
   parameter bit EXPAND_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_imm,
   input  logic [2:0]  in_imm_type,
   input  logic        in_expand,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic        out_err,
   output logic        out_last
);

   enc_state_e  state_q, state_d;
   logic [31:0] out_inst_q, out_inst_d;
   logic        out_err_q, out_err_d;
   logic        out_last_q, out_last_d;
   logic [31:0] lo_inst_q, lo_inst_d;

   logic [31:0] pack_inst;
   logic        pack_err;
   logic        accept;
   logic        expand;
   logic [4:0]  rd;
   logic [19:0] hi;
   logic [31:0] lui_word;
   logic [31:0] addi_word;

   imm_pack u_pack (
      .inst        (in_inst),
      .imm         (in_imm),
      .imm_type    (in_imm_type),
      .packed_inst (pack_inst),
      .err         (pack_err)
   );

   assign accept = in_valid & in_ready;

   // Only a genuine ADDI that does not fit 12 bits is split.
   assign expand = EXPAND_EN & in_expand & (in_imm_type == IMM_I) & pack_err &
                   (in_inst[6:0] == OP_OPIMM) & (in_inst[14:12] == F3_ADDI);

   assign rd = in_inst[11:7];
   // ADDI sign-extends its 12 bits, so round the upper part up when imm[11] is set.
   assign hi        = in_imm[31:12] + {19'd0, in_imm[11]};
   assign lui_word  = {hi, rd, OP_LUI};
   assign addi_word = {in_imm[11:0], rd, F3_ADDI, rd, OP_OPIMM};

   always_comb begin
      in_ready = 1'b0;
      unique case (state_q)
         S_IDLE:      in_ready = 1'b1;
         S_ONE, S_LO: in_ready = out_ready;
         S_HI:        in_ready = 1'b0;
         default:     in_ready = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      out_inst_d = out_inst_q;
      out_err_d  = out_err_q;
      out_last_d = out_last_q;
      lo_inst_d  = lo_inst_q;
      unique case (state_q)
         S_IDLE, S_ONE, S_LO: begin
            if (accept) begin
               if (expand) begin
                  state_d    = S_HI;
                  out_inst_d = lui_word;
                  out_err_d  = 1'b0;
                  out_last_d = 1'b0;
                  lo_inst_d  = addi_word;
               end else begin
                  state_d    = S_ONE;
                  out_inst_d = pack_inst;
                  out_err_d  = pack_err;
                  out_last_d = 1'b1;
               end
            end else if ((state_q != S_IDLE) && out_ready) begin
               state_d = S_IDLE;
            end
         end
         S_HI: begin
            if (out_ready) begin
               state_d    = S_LO;
               out_inst_d = lo_inst_q;
               out_err_d  = 1'b0;
               out_last_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         out_inst_q <= 32'd0;
         out_err_q  <= 1'b0;
         out_last_q <= 1'b0;
         lo_inst_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         out_inst_q <= out_inst_d;
         out_err_q  <= out_err_d;
         out_last_q <= out_last_d;
         lo_inst_q  <= lo_inst_d;
      end
   end

   assign out_valid = (state_q != S_IDLE);
   assign out_inst  = out_inst_q;
   assign out_err   = out_err_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed cases plus a randomized run whose words are
// decoded back by an independent immediate decoder and checked against an
// arithmetic model of range limits and truncation.
module tb_imm_encoder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_imm;
   logic [2:0]  in_imm_type;
   logic        in_expand;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_err;
   logic        out_last;

   int vectors = 0;
   int miscompares = 0;

   imm_encoder #(.EXPAND_EN(1'b1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_inst     (in_inst),
      .in_imm      (in_imm),
      .in_imm_type (in_imm_type),
      .in_expand   (in_expand),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_inst    (out_inst),
      .out_err     (out_err),
      .out_last    (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Reduce v into the signed range of a k-bit field.
   function automatic logic [31:0] wrapk(input logic [31:0] v, input int k);
      longint m, r;
      m = longint'(1) << k;
      r = longint'($signed(v));
      r = ((r + m / 2) % m + m) % m - m / 2;
      return r[31:0];
   endfunction

   function automatic bit in_range(input logic [31:0] imm, input logic [2:0] t);
      longint s;
      s = longint'($signed(imm));
      case (t)
         3'd0, 3'd1: return (s >= -2048) && (s <= 2047);
         3'd2:       return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
         3'd3:       return (imm % 4096) == 0;
         3'd4:       return (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
         default:    return 1'b0;
      endcase
   endfunction

   // Value the decoder should recover, including truncation when out of range.
   function automatic logic [31:0] exp_value(input logic [31:0] imm, input logic [2:0] t);
      logic [31:0] w;
      case (t)
         3'd0, 3'd1: return wrapk(imm, 12);
         3'd2: begin w = wrapk(imm, 13); return w - (w % 2); end
         3'd3: return imm - (imm % 4096);
         3'd4: begin w = wrapk(imm, 21); return w - (w % 2); end
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] field_mask(input logic [2:0] t);
      case (t)
         3'd0:       return 32'hFFF0_0000;
         3'd1, 3'd2: return 32'hFE00_0F80;
         3'd3, 3'd4: return 32'hFFFF_F000;
         default:    return 32'h0000_0000;
      endcase
   endfunction

   // Standard RV32I immediate decoder.
   function automatic logic [31:0] decode(input logic [31:0] i, input logic [2:0] t);
      case (t)
         3'd0: return {{20{i[31]}}, i[31:20]};
         3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
         3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd3: return {i[31:12], 12'd0};
         3'd4: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: return 32'd0;
      endcase
   endfunction

   // ---------------- drivers ----------------
   task automatic set_req(input logic [31:0] tmpl, input logic [31:0] imm,
                          input logic [2:0] t, input logic ex);
      in_inst = tmpl; in_imm = imm; in_imm_type = t; in_expand = ex;
   endtask

   // Issue one non-expanding request from idle, sample the held word, then drain.
   task automatic issue_single(input logic [31:0] tmpl, input logic [31:0] imm,
                               input logic [2:0] t, input logic ex,
                               output logic [31:0] o_inst, output logic o_err,
                               output logic o_last, output logic o_valid);
      set_req(tmpl, imm, t, ex);
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      o_inst = out_inst; o_err = out_err; o_last = out_last; o_valid = out_valid;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++;
         $display("FAIL reset_valid: got %b want 0", out_valid); end
      vectors++; if (out_inst !== 32'd0) begin miscompares++;
         $display("FAIL reset_inst: got %h want 00000000", out_inst); end
      vectors++; if ({out_err, out_last} !== 2'b00) begin miscompares++;
         $display("FAIL reset_err_last: got %b want 00", {out_err, out_last}); end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++; if (in_ready !== 1'b1) begin miscompares++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_pack();
      logic [31:0] oi; logic oe, ol, ov;
      issue_single(32'h0000_0293, 32'hFFFF_F800, 3'd0, 1'b0, oi, oe, ol, ov);
      vectors++; if ({ov, oi, oe, ol} !== {1'b1, 32'h8000_0293, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL pack_i: got v%b %h e%b l%b want v1 80000293 e0 l1", ov, oi, oe, ol);
      end
      vectors++; if (out_valid !== 1'b0) begin miscompares++;
         $display("FAIL pack_i_drain: got valid %b want 0", out_valid); end
      issue_single(32'h0000_A023, 32'h0000_07FC, 3'd1, 1'b0, oi, oe, ol, ov);
      vectors++; if ({oi, oe} !== {32'h7E00_AE23, 1'b0}) begin miscompares++;
         $display("FAIL pack_s: got %h e%b want 7e00ae23 e0", oi, oe); end
   endtask

   task automatic test_range();
      logic [31:0] oi; logic oe, ol, ov;
      issue_single(32'h0000_0063, 32'h0000_0003, 3'd2, 1'b0, oi, oe, ol, ov);
      vectors++; if (oe !== 1'b1) begin miscompares++;
         $display("FAIL range_b_odd: got err %b want 1", oe); end
      issue_single(32'h0000_0293, 32'h0000_0800, 3'd0, 1'b0, oi, oe, ol, ov);
      vectors++; if ({oi, oe, ol} !== {32'h8000_0293, 1'b1, 1'b1}) begin miscompares++;
         $display("FAIL range_i_800: got %h e%b l%b want 80000293 e1 l1", oi, oe, ol); end
      issue_single(32'h0000_0293, 32'h0000_07FF, 3'd0, 1'b1, oi, oe, ol, ov);
      vectors++; if ({oi, oe} !== {32'h7FF0_0293, 1'b0}) begin miscompares++;
         $display("FAIL range_i_7ff: got %h e%b want 7ff00293 e0", oi, oe); end
      issue_single(32'h0000_0037, 32'h1234_5678, 3'd3, 1'b0, oi, oe, ol, ov);
      vectors++; if ({oi, oe} !== {32'h1234_5037, 1'b1}) begin miscompares++;
         $display("FAIL range_u_low: got %h e%b want 12345037 e1", oi, oe); end
      issue_single(32'h0000_006F, 32'h000F_FFFE, 3'd4, 1'b0, oi, oe, ol, ov);
      vectors++; if ({oi, oe} !== {32'h7FFF_F06F, 1'b0}) begin miscompares++;
         $display("FAIL range_j_max: got %h e%b want 7ffff06f e0", oi, oe); end
      issue_single(32'h0000_006F, 32'h0010_0000, 3'd4, 1'b0, oi, oe, ol, ov);
      vectors++; if (oe !== 1'b1) begin miscompares++;
         $display("FAIL range_j_over: got err %b want 1", oe); end
      issue_single(32'hDEAD_BEEF, 32'h0000_0004, 3'd6, 1'b0, oi, oe, ol, ov);
      vectors++; if ({oi, oe} !== {32'hDEAD_BEEF, 1'b1}) begin miscompares++;
         $display("FAIL range_bad_type: got %h e%b want deadbeef e1", oi, oe); end
   endtask

   task automatic test_expand();
      set_req(32'h0000_0293, 32'h1234_5FFF, 3'd0, 1'b1);
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      vectors++; if ({out_valid, out_inst, out_err, out_last} !==
                     {1'b1, 32'h1234_62B7, 1'b0, 1'b0}) begin miscompares++;
         $display("FAIL expand_lui: got v%b %h e%b l%b want v1 123462b7 e0 l0",
                  out_valid, out_inst, out_err, out_last); end
      out_ready = 1'b1; in_valid = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++;
         $display("FAIL expand_hi_ready: got %b want 0", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      vectors++; if ({out_valid, out_inst, out_err, out_last} !==
                     {1'b1, 32'hFFF2_8293, 1'b0, 1'b1}) begin miscompares++;
         $display("FAIL expand_addi: got v%b %h e%b l%b want v1 fff28293 e0 l1",
                  out_valid, out_inst, out_err, out_last); end
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++;
         $display("FAIL expand_drain: got valid %b want 0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int bad;
      set_req(32'h0000_0013, 32'h0000_0005, 3'd0, 1'b0);
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      set_req(32'h0000_0013, 32'h0000_0006, 3'd0, 1'b0);
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== 32'h0050_0013) bad++;
         @(negedge clk);
      end
      vectors++; if (bad != 0) begin miscompares++;
         $display("FAIL bp_hold: got %0d unstable cycles want 0 (inst %h)", bad, out_inst); end
      out_ready = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++;
         $display("FAIL bp_drain_ready: got %b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      vectors++; if ({out_valid, out_inst} !== {1'b1, 32'h0060_0013}) begin miscompares++;
         $display("FAIL bp_next: got v%b %h want v1 00600013", out_valid, out_inst); end
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++;
         $display("FAIL bp_no_dup: got valid %b want 0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_in_hi();
      int seen;
      set_req(32'h0000_0293, 32'h1234_5FFF, 3'd0, 1'b1);
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      vectors++; if ({out_valid, out_last} !== 2'b10) begin miscompares++;
         $display("FAIL rst_hi_pre: got v%b l%b want v1 l0", out_valid, out_last); end
      rst_n = 1'b0;
      #1;
      vectors++; if ({out_valid, out_inst} !== {1'b0, 32'd0}) begin miscompares++;
         $display("FAIL rst_hi_clear: got v%b %h want v0 00000000", out_valid, out_inst); end
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen++;
      end
      vectors++; if (seen != 0) begin miscompares++;
         $display("FAIL rst_hi_no_addi: got %0d valid cycles want 0", seen); end
      out_ready = 1'b0;
   endtask

   typedef struct {
      logic [31:0] tmpl;
      logic [31:0] imm;
      logic [2:0]  t;
      int          kind;  // 0 single word, 1 LUI, 2 ADDI
   } exp_t;

   task automatic test_random();
      localparam int NREQ = 10000;
      exp_t q[$];
      exp_t e, e2;
      int sent, budget;
      bit acc;
      logic [31:0] tmpl, imm, keep, mask, val;
      logic [2:0] t, td;
      logic ex, exp_err, exp_last;
      int r;
      sent = 0; budget = 0;
      in_valid = 1'b0;
      while ((sent < NREQ || q.size() != 0) && budget < 60000) begin
         if (!in_valid && sent < NREQ && $urandom_range(0, 7) != 0) begin
            tmpl = $urandom;
            if ($urandom_range(0, 1) == 1) begin
               tmpl[6:0] = 7'h13; tmpl[14:12] = 3'd0;
            end
            case ($urandom_range(0, 3))
               0: imm = $urandom;
               1: imm = $urandom_range(0, 8191) - 4096;
               2: imm = $urandom & 32'hFFFF_F000;
               default: imm = $urandom_range(0, 2097151) - 1048576;
            endcase
            r = $urandom_range(0, 9);
            t = (r > 7) ? 3'd0 : r[2:0];
            ex = $urandom_range(0, 1) == 1;
            set_req(tmpl, imm, t, ex);
            in_valid = 1'b1;
         end
         out_ready = ($urandom_range(0, 7) != 0);
         #1;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL rnd_extra_word: got %h want no word", out_inst);
            end else begin
               e = q.pop_front();
               if (e.kind == 1) begin
                  td = 3'd3; mask = field_mask(3'd3);
                  keep = {20'd0, e.tmpl[11:7], 7'h37};
                  val = e.imm - wrapk(e.imm, 12);
                  exp_err = 1'b0; exp_last = 1'b0;
               end else if (e.kind == 2) begin
                  td = 3'd0; mask = field_mask(3'd0);
                  keep = {12'd0, e.tmpl[11:7], 3'd0, e.tmpl[11:7], 7'h13};
                  val = wrapk(e.imm, 12);
                  exp_err = 1'b0; exp_last = 1'b1;
               end else begin
                  td = e.t; mask = field_mask(e.t);
                  keep = e.tmpl & ~mask;
                  val = exp_value(e.imm, e.t);
                  exp_err = !in_range(e.imm, e.t); exp_last = 1'b1;
               end
               vectors++; if ({out_err, out_last} !== {exp_err, exp_last}) begin
                  miscompares++;
                  $display("FAIL rnd_flags: got e%b l%b want e%b l%b (imm %h type %0d)",
                           out_err, out_last, exp_err, exp_last, e.imm, e.t);
               end
               vectors++; if ((out_inst & ~mask) !== keep) begin miscompares++;
                  $display("FAIL rnd_keep: got %h want %h (tmpl %h type %0d kind %0d)",
                           out_inst & ~mask, keep, e.tmpl, e.t, e.kind);
               end
               if (td <= 3'd4) begin
                  vectors++; if (decode(out_inst, td) !== val) begin miscompares++;
                     $display("FAIL rnd_value: got %h want %h (imm %h type %0d kind %0d)",
                              decode(out_inst, td), val, e.imm, e.t, e.kind);
                  end
               end
            end
         end
         acc = in_valid && in_ready;
         if (acc) begin
            e.tmpl = in_inst; e.imm = in_imm; e.t = in_imm_type; e.kind = 0;
            if (in_expand && in_imm_type == 3'd0 && !in_range(in_imm, 3'd0) &&
                in_inst[6:0] == 7'h13 && in_inst[14:12] == 3'd0) begin
               e.kind = 1; e2 = e; e2.kind = 2;
               q.push_back(e); q.push_back(e2);
            end else begin
               q.push_back(e);
            end
            sent++;
         end
         @(negedge clk);
         if (acc) in_valid = 1'b0;
         budget++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      vectors++; if (sent != NREQ || q.size() != 0) begin miscompares++;
         $display("FAIL rnd_budget: got %0d sent %0d pending want %0d sent 0 pending",
                  sent, q.size(), NREQ);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_inst = 32'd0; in_imm = 32'd0; in_imm_type = 3'd0; in_expand = 1'b0;
      test_reset();
      test_pack();
      test_range();
      test_expand();
      test_backpressure();
      test_reset_in_hi();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
